// File: rtl/ps2_key_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : ps2_key_decoder_if
// Description : PS/2 pins plus per-key status and error reporting bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface ps2_key_decoder_if #(
    parameter int NUM_KEYS = 9
);
    logic                ps2_clk;
    logic                ps2_data;
    logic [NUM_KEYS-1:0] key_down;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;
    logic [NUM_KEYS-1:0] key_toggle;
    logic                frame_err;
    logic [7:0]          err_count;

    modport master (
        input  ps2_clk, ps2_data,
        output key_down, key_press, key_release, key_toggle, frame_err, err_count
    );

    modport slave (
        output ps2_clk, ps2_data,
        input  key_down, key_press, key_release, key_toggle, frame_err, err_count
    );
endinterface
`default_nettype wire

// File: rtl/ps2_key_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ps2_key_decoder
// Description : PS/2 frame receiver with timeout and make/break key decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_decoder #(
    parameter int                    SYNC_STAGES    = 3,
    parameter int                    TIMEOUT_CYCLES = 100000,
    parameter int                    NUM_KEYS       = 9,
    parameter logic [NUM_KEYS*9-1:0] KEY_CODES      = {9'h04D, 9'h03A, 9'h076, 9'h029, 9'h175,
                                                       9'h172, 9'h16B, 9'h174, 9'h05A}
) (
    input  logic                   clk,
    input  logic                   rst,
    ps2_key_decoder_if.master      bus
);
    localparam int                  c_idle_w  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_idle_w-1:0] c_timeout = c_idle_w'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    logic [SYNC_STAGES-1:0] sclk_q, sclk_d, sdat_q, sdat_d;
    logic                   clk_prev_q, clk_prev_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [9:0]             shift_q, shift_d;
    logic [c_idle_w-1:0]    idle_q, idle_d;
    logic                   byte_valid_q, byte_valid_d;
    logic [7:0]             byte_q, byte_d;
    logic                   frame_err_q, frame_err_d;
    state_t                 state_q, state_d;
    logic [NUM_KEYS-1:0]    key_down_q, key_down_d;
    logic [NUM_KEYS-1:0]    key_press_q, key_press_d;
    logic [NUM_KEYS-1:0]    key_release_q, key_release_d;
    logic [NUM_KEYS-1:0]    key_toggle_q, key_toggle_d;
    logic [7:0]             err_count_q, err_count_d;

    logic                   w_sclk, w_sdat, w_fall;
    logic [10:0]            w_frame;
    logic                   w_make, w_brk, w_ext;

    assign w_sclk  = sclk_q[SYNC_STAGES-1];
    assign w_sdat  = sdat_q[SYNC_STAGES-1];
    assign w_fall  = clk_prev_q & ~w_sclk;
    assign w_frame = {w_sdat, shift_q};

    // Receiver: frame assembly, validation and stalled-frame timeout
    always_comb begin
        sclk_d       = {sclk_q[SYNC_STAGES-2:0], bus.ps2_clk};
        sdat_d       = {sdat_q[SYNC_STAGES-2:0], bus.ps2_data};
        clk_prev_d   = w_sclk;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        idle_d       = idle_q;
        byte_valid_d = 1'b0;
        byte_d       = byte_q;
        frame_err_d  = 1'b0;
        if (w_fall) begin
            idle_d  = '0;
            shift_d = {w_sdat, shift_q[9:1]};
            if (bit_cnt_q == 4'd10) begin
                bit_cnt_d = 4'd0;
                if (!w_frame[0] && (^w_frame[9:1]) && w_frame[10]) begin
                    byte_valid_d = 1'b1;
                    byte_d       = w_frame[8:1];
                end else begin
                    frame_err_d  = 1'b1;
                end
            end else begin
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end else if (bit_cnt_q != 4'd0) begin
            if (idle_q == c_timeout) begin
                bit_cnt_d   = 4'd0;
                idle_d      = '0;
                frame_err_d = 1'b1;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end else begin
            idle_d = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        w_make  = 1'b0;
        w_brk   = 1'b0;
        w_ext   = 1'b0;
        if (frame_err_q) begin
            state_d = IDLE;
        end else if (byte_valid_q) begin
            case (state_q)
                IDLE: begin
                    if (byte_q == 8'hE0)      state_d = EXT;
                    else if (byte_q == 8'hF0) state_d = BRK;
                    else                      w_make  = 1'b1;
                end
                EXT: begin
                    if (byte_q == 8'hE0) begin
                        state_d = EXT;
                    end else if (byte_q == 8'hF0) begin
                        state_d = EXT_BRK;
                    end else begin
                        w_make  = 1'b1;
                        w_ext   = 1'b1;
                        state_d = IDLE;
                    end
                end
                BRK: begin
                    w_brk   = 1'b1;
                    state_d = IDLE;
                end
                default: begin
                    w_brk   = 1'b1;
                    w_ext   = 1'b1;
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Every matching table entry reacts; repeats and stray breaks are ignored
    always_comb begin
        key_down_d    = key_down_q;
        key_press_d   = '0;
        key_release_d = '0;
        key_toggle_d  = key_toggle_q;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if ({w_ext, byte_q} == KEY_CODES[9*i +: 9]) begin
                if (w_make && !key_down_q[i]) begin
                    key_down_d[i]   = 1'b1;
                    key_press_d[i]  = 1'b1;
                    key_toggle_d[i] = ~key_toggle_q[i];
                end
                if (w_brk && key_down_q[i]) begin
                    key_down_d[i]    = 1'b0;
                    key_release_d[i] = 1'b1;
                end
            end
        end
        err_count_d = err_count_q;
        if (frame_err_q && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q        <= '1;
            sdat_q        <= '1;
            clk_prev_q    <= 1'b1;
            bit_cnt_q     <= 4'd0;
            shift_q       <= '0;
            idle_q        <= '0;
            byte_valid_q  <= 1'b0;
            byte_q        <= 8'd0;
            frame_err_q   <= 1'b0;
            state_q       <= IDLE;
            key_down_q    <= '0;
            key_press_q   <= '0;
            key_release_q <= '0;
            key_toggle_q  <= '0;
            err_count_q   <= 8'd0;
        end else begin
            sclk_q        <= sclk_d;
            sdat_q        <= sdat_d;
            clk_prev_q    <= clk_prev_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            idle_q        <= idle_d;
            byte_valid_q  <= byte_valid_d;
            byte_q        <= byte_d;
            frame_err_q   <= frame_err_d;
            state_q       <= state_d;
            key_down_q    <= key_down_d;
            key_press_q   <= key_press_d;
            key_release_q <= key_release_d;
            key_toggle_q  <= key_toggle_d;
            err_count_q   <= err_count_d;
        end
    end

    assign bus.key_down    = key_down_q;
    assign bus.key_press   = key_press_q;
    assign bus.key_release = key_release_q;
    assign bus.key_toggle  = key_toggle_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.err_count   = err_count_q;
endmodule
`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_key_decoder
// Description : Directed self-checking bench for ps2_key_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_key_decoder;
    localparam int HALF = 6;
    localparam int TMO  = 200;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ps2_key_decoder_if #(.NUM_KEYS(9)) bus();

    ps2_key_decoder #(
        .SYNC_STAGES    (3),
        .TIMEOUT_CYCLES (TMO),
        .NUM_KEYS       (9)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int press_cnt [9];
    int rel_cnt   [9];
    int ferr_cnt;

    logic [8:0] press_n1, press_n2;
    logic       ferr_n1;
    logic [7:0] ec_n2;

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) begin
                press_cnt[i] = 0;
                rel_cnt[i]   = 0;
            end
            ferr_cnt = 0;
        end else begin
            for (int i = 0; i < 9; i++) begin
                press_cnt[i] = press_cnt[i] + int'(bus.key_press[i]);
                rel_cnt[i]   = rel_cnt[i] + int'(bus.key_release[i]);
            end
            ferr_cnt = ferr_cnt + int'(bus.frame_err);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One PS/2 bit; snapshots taken 4 and 5 clks after the falling pin edge
    task automatic send_bit(input logic b);
        bus.ps2_data = b;
        repeat (HALF) @(negedge clk);
        bus.ps2_clk = 1'b0;
        for (int c = 1; c <= HALF; c++) begin
            @(posedge clk);
            #1;
            if (c == 4) begin
                press_n1 = bus.key_press;
                ferr_n1  = bus.frame_err;
            end
            if (c == 5) begin
                press_n2 = bus.key_press;
                ec_n2    = bus.err_count;
            end
        end
        @(negedge clk);
        bus.ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        logic [10:0] frm;
        frm = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i <= 10; i++) send_bit(frm[i]);
        bus.ps2_data = 1'b1;
        repeat (16) @(negedge clk);
    endtask

    task automatic send_ok(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0);
    endtask

    initial begin
        int          seen;
        logic [10:0] frm;
        rst          = 1'b1;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst_down",   32'(bus.key_down),   32'h0);
        chk("rst_toggle", 32'(bus.key_toggle), 32'h0);
        chk("rst_ferr",   32'(bus.frame_err),  32'h0);
        chk("rst_errcnt", 32'(bus.err_count),  32'h0);

        send_ok(8'h29);
        chk("29_press_n1", 32'(press_n1),       32'h000);
        chk("29_press_n2", 32'(press_n2),       32'h020);
        chk("29_down",     32'(bus.key_down),   32'h020);
        chk("29_toggle",   32'(bus.key_toggle), 32'h020);

        send_ok(8'h29);
        send_ok(8'h29);
        chk("typ_down", 32'(bus.key_down), 32'h020);
        send_ok(8'hF0);
        send_ok(8'h29);
        chk("typ_press_cnt", 32'(press_cnt[5]),  32'd1);
        chk("typ_rel_cnt",   32'(rel_cnt[5]),    32'd1);
        chk("typ_down_off",  32'(bus.key_down),  32'h000);

        send_ok(8'hE0);
        send_ok(8'h75);
        chk("up_down",  32'(bus.key_down), 32'h010);
        chk("up_press", 32'(press_cnt[4]), 32'd1);
        send_ok(8'hE0);
        send_ok(8'hF0);
        send_ok(8'h75);
        chk("up_rel",      32'(rel_cnt[4]),   32'd1);
        chk("up_down_off", 32'(bus.key_down), 32'h000);

        send_ok(8'h75);
        chk("plain75_down", 32'(bus.key_down), 32'h000);
        send_ok(8'hF0);
        send_ok(8'h75);
        send_ok(8'hAA);
        send_ok(8'hFA);
        chk("plain75_press", 32'(press_cnt[4]),   32'd1);
        chk("plain75_rel",   32'(rel_cnt[4]),     32'd1);
        chk("plain_toggle",  32'(bus.key_toggle), 32'h030);
        chk("unmatched_dn",  32'(bus.key_down),   32'h000);

        send_ok(8'h3A);
        chk("m_toggle1", 32'(bus.key_toggle), 32'h0B0);
        send_ok(8'hF0);
        send_ok(8'h3A);
        send_ok(8'h3A);
        chk("m_toggle2", 32'(bus.key_toggle), 32'h030);
        send_ok(8'hF0);
        send_ok(8'h3A);
        chk("m_press_cnt", 32'(press_cnt[7]), 32'd2);
        chk("m_rel_cnt",   32'(rel_cnt[7]),   32'd2);

        send_frame(8'h5A, 1'b1, 1'b0);
        chk("par_ferr",   32'(ferr_n1),      32'h1);
        chk("par_errcnt", 32'(ec_n2),        32'h1);
        chk("par_press",  32'(press_n2),     32'h000);
        chk("par_down",   32'(bus.key_down), 32'h000);
        chk("par_pulses", 32'(ferr_cnt),     32'd1);
        send_ok(8'h5A);
        chk("enter_down", 32'(bus.key_down), 32'h001);
        send_ok(8'hF0);
        send_ok(8'h5A);

        // Five bits of a 76 frame, then the bus stalls
        frm = {1'b1, ~^8'h76, 8'h76, 1'b0};
        for (int i = 0; i < 4; i++) send_bit(frm[i]);
        bus.ps2_data = frm[4];
        repeat (HALF) @(negedge clk);
        bus.ps2_clk = 1'b0;
        seen = -1;
        for (int c = 1; c <= TMO + 40; c++) begin
            @(posedge clk);
            #1;
            if (c == HALF) bus.ps2_clk = 1'b1;
            if (bus.frame_err && seen < 0) seen = c;
        end
        bus.ps2_data = 1'b1;
        repeat (16) @(negedge clk);
        chk("tmo_latency", 32'(seen),          32'(TMO + 5));
        chk("tmo_pulses",  32'(ferr_cnt),      32'd2);
        chk("tmo_errcnt",  32'(bus.err_count), 32'd2);
        send_ok(8'h76);
        chk("tmo_next_press", 32'(press_cnt[6]), 32'd1);
        chk("tmo_next_down",  32'(bus.key_down), 32'h040);

        for (int n = 0; n < 300; n++) begin
            send_frame(8'(n), 1'b1, n[0]);
        end
        chk("sat_errcnt", 32'(bus.err_count), 32'd255);
        chk("sat_pulses", 32'(ferr_cnt),      32'd302);
        chk("sat_down",   32'(bus.key_down),  32'h040);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Parametrised PS/2 keyboard front end for the Tetris FPGA design. It receives PS/2 device-to-host frames and validates start, parity and stop bits. It recovers from stalled frames with a timeout and decodes make/break/extended sequences against a configurable key table. It sits between the board PS/2 pins and the game controller, and gives per-key held levels, press/release pulses, toggles and error reporting.

## Interface
- SYNC_STAGES, 3: synchroniser depth for ps2_clk and ps2_data. Minimum 2.
- TIMEOUT_CYCLES, 100000: clk cycles with no PS/2 falling edge before a partial frame is aborted (2 ms at 50 MHz).
- NUM_KEYS, 9: number of key table entries. Range 1..32.
- KEY_CODES, NUM_KEYS*9 bits: entry i occupies bits [9i+8:9i] as {ext, code[7:0]}. Default, index 0..8: Enter {0,5A}, Right {1,74}, Left {1,6B}, Down {1,72}, Up {1,75}, Space {0,29}, Esc {0,76}, M {0,3A}, P {0,4D}.
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- ps2_clk  in  1  raw PS/2 clock, asynchronous.
- ps2_data  in  1  raw PS/2 data, asynchronous.
- key_down  out  NUM_KEYS  level; 1 while the key is held.
- key_press  out  NUM_KEYS  1-cycle pulse on the first make of a key.
- key_release  out  NUM_KEYS  1-cycle pulse on break of a held key.
- key_toggle  out  NUM_KEYS  flips on every key_press.
- frame_err  out  1  1-cycle pulse on a bad frame or timeout.
- err_count  out  8  count of frame_err pulses; saturates at 255.

## Operation
- Synchroniser: SYNC_STAGES flops per input, reset to 1. A falling edge is defined as previous synced clk = 1 and current synced clk = 0.
- Receiver: bit counter 0..10. Each falling edge shifts in synced data, LSB first, and advances the counter. Frame format: start = 0, data[7:0], odd parity, stop = 1.
- On the 11th bit the counter returns to 0. If start = 0, the XOR of data and parity = 1, and stop = 1, byte_valid pulses with the byte. Otherwise frame_err pulses and the byte is discarded.
- Timeout: an idle counter clears on every falling edge. If it reaches TIMEOUT_CYCLES while the bit counter is nonzero, the bit counter resets to 0 and frame_err pulses. An idle bus (bit counter = 0) never times out.
- Decoder FSM, states IDLE, EXT, BRK, EXT_BRK. It advances only on byte_valid:
  - IDLE: E0 -> EXT. F0 -> BRK. Any other byte -> make{0,byte}, stay IDLE.
  - EXT: E0 -> EXT. F0 -> EXT_BRK. Any other byte -> make{1,byte}, then IDLE.
  - BRK: any byte -> break{0,byte}, then IDLE.
  - EXT_BRK: any byte -> break{1,byte}, then IDLE.
  - Any frame_err forces IDLE.
- Match: every table entry equal to {ext, code} is acted on in parallel. Unmatched codes (e.g. AA, FA) have no effect.
- Make on entry i:
  - If key_down[i] = 0: set key_down[i], pulse key_press[i], flip key_toggle[i].
  - If already 1 (typematic repeat): no action.
- Break on entry i:
  - If key_down[i] = 1: clear it and pulse key_release[i].
  - Otherwise: no action.
- err_count increments on each frame_err and holds at 255.

## Timing
- Reset values: key_down, key_press, key_release, key_toggle, frame_err, err_count = 0. FSM = IDLE, bit counter = 0, synchroniser flops = 1.
- Reset is honoured on any cycle. A frame in progress is discarded with no frame_err.
- Input latency is SYNC_STAGES cycles, pin to synced signal.
- Cycle N: synced falling edge of the stop bit. N+1: byte_valid / frame_err registered. N+2: key_down, key_press, key_release, key_toggle updated. err_count updates at N+2.
- Timeout: frame_err asserts exactly 1 cycle after the idle counter reaches TIMEOUT_CYCLES.
- Falling edge and timeout in the same cycle: the edge wins and no error is raised.
- Pulse outputs are high for exactly 1 clk cycle. Byte spacing is at least hundreds of cycles, so the decoder needs no buffering.

## Test plan
- Frame 29 (data LSB-first 1,0,0,1,0,1,0,0, parity 0): key_press[5] pulses once at N+2, key_down[5] = 1, key_toggle[5] = 1.
- Sequence 29, 29, 29 (typematic) then F0 29: one key_press[5] pulse only. key_release[5] pulses after 29, key_down[5] = 0.
- E0 75, then E0 F0 75: key_press[4] then key_release[4]. Plain 75 and F0 75 leave all outputs at 0.
- 3A press/release twice: key_toggle[7] goes 1 then 0. key_press[7] pulses twice.
- Frame 5A sent with parity 1: frame_err pulses, err_count = 1, no key activity. A following valid 5A sets key_down[0].
- Stop after 5 bits, then idle TIMEOUT_CYCLES: frame_err, counter cleared, and the next full 76 frame decodes (key_press[6]). Driving 300 bad frames leaves err_count at 255.
